// File: rtl/divisor_punto_fijo_pkg.sv
// Shared Q-format constants, saturation limits and FSM encoding for the
// filter's fixed-point multiplier and divider paths.
package divisor_punto_fijo_pkg;

  localparam int Width     = 25;
  localparam int Presicion = 16;
  localparam int Magnitud  = Width - Presicion - 1;

  // One quotient bit per numerator bit: |A| * 2^Presicion
  localparam int N_ITER = Width + Presicion;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  // Symmetric saturation: the most negative code is never produced
  localparam logic [Width-1:0] maximo = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] minimo = {1'b1, {(Width-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIN    = 2'd2
  } estado_t;

  // |x| as unsigned; |-2^(Width-1)| = 2^(Width-1) still fits
  function automatic logic [Width-1:0] abs_val(input logic [Width-1:0] x);
    return x[Width-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/divisor_punto_fijo_if.sv
// Start/result handshake of the fixed-point divider.
interface divisor_punto_fijo_if;
  import divisor_punto_fijo_pkg::*;

  logic             start;
  logic [Width-1:0] A;
  logic [Width-1:0] B;
  logic [Width-1:0] Y;
  logic             valido;
  logic             ocupado;
  logic             desborde;
  logic             div_cero;

  modport master (
    output start, A, B,
    input  Y, valido, ocupado, desborde, div_cero
  );

  modport slave (
    input  start, A, B,
    output Y, valido, ocupado, desborde, div_cero
  );

endinterface

// File: rtl/divisor_punto_fijo_nucleo_sin_signo.sv
// Unsigned restoring divider core: one quotient bit per paso cycle,
// numerator is num_abs * 2^Presicion.
module divisor_nucleo_sin_signo
  import divisor_punto_fijo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cargar,
  input  logic              paso,
  input  logic [Width-1:0]  num_abs,
  input  logic [Width-1:0]  den_abs,
  output logic [N_ITER-1:0] q,
  output logic              listo
);

  logic [N_ITER-1:0] num;
  logic [Width-1:0]  den;
  logic [Width:0]    rem;
  logic [CNT_W-1:0]  cnt;

  logic [Width:0] rem_sh;
  logic [Width:0] resta;
  logic           cabe;

  assign rem_sh = {rem[Width-1:0], num[N_ITER-1]};
  assign cabe   = (rem_sh >= {1'b0, den});
  assign resta  = rem_sh - {1'b0, den};
  // High during the last iteration, so the FSM leaves DIVIDE with it
  assign listo  = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num <= '0;
      den <= '0;
      rem <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (cargar) begin
      num <= {num_abs, {Presicion{1'b0}}};
      den <= den_abs;
      rem <= '0;
      q   <= '0;
      cnt <= CNT_W'(N_ITER);
    end else if (paso && cnt != '0) begin
      num <= {num[N_ITER-2:0], 1'b0};
      rem <= cabe ? resta : rem_sh;
      q   <= {q[N_ITER-2:0], cabe};
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/divisor_punto_fijo.sv
// Sequential saturating signed fixed-point divider Y = A/B: sign/magnitude
// handling, FSM, saturation and output registers around the unsigned core.
module divisor_punto_fijo
  import divisor_punto_fijo_pkg::*;
(
  input logic clk,
  input logic rst_n,
  divisor_punto_fijo_if.slave bus
);

  localparam logic [N_ITER-1:0] Q_MAX = {{(N_ITER-Width){1'b0}}, maximo};

  estado_t estado, estado_sig;
  logic    signo, a_cero, b_cero;
  logic    cargar, paso, listo;

  logic [Width-1:0]  a_abs, b_abs;
  logic [N_ITER-1:0] q;
  logic [Width-1:0]  y_sig;
  logic              desb_sig, dz_sig;

  assign a_abs = abs_val(bus.A);
  assign b_abs = abs_val(bus.B);

  divisor_nucleo_sin_signo u_nucleo (
    .clk     (clk),
    .rst_n   (rst_n),
    .cargar  (cargar),
    .paso    (paso),
    .num_abs (a_abs),
    .den_abs (b_abs),
    .q       (q),
    .listo   (listo)
  );

  always_comb begin
    estado_sig = estado;
    cargar     = 1'b0;
    paso       = 1'b0;
    case (estado)
      IDLE: if (bus.start) begin
        cargar     = 1'b1;
        estado_sig = (bus.A == '0 || bus.B == '0) ? FIN : DIVIDE;
      end
      DIVIDE: begin
        paso = 1'b1;
        if (listo) estado_sig = FIN;
      end
      FIN:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  // A==0 wins over B==0, so 0/0 yields a clean zero
  always_comb begin
    y_sig    = '0;
    desb_sig = 1'b0;
    dz_sig   = 1'b0;
    if (a_cero) begin
      y_sig = '0;
    end else if (b_cero) begin
      y_sig    = signo ? minimo : maximo;
      desb_sig = 1'b1;
      dz_sig   = 1'b1;
    end else if (q > Q_MAX) begin
      y_sig    = signo ? minimo : maximo;
      desb_sig = 1'b1;
    end else begin
      y_sig = signo ? (~q[Width-1:0] + 1'b1) : q[Width-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_sig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signo  <= 1'b0;
      a_cero <= 1'b0;
      b_cero <= 1'b0;
    end else if (cargar) begin
      signo  <= bus.A[Width-1] ^ bus.B[Width-1];
      a_cero <= (bus.A == '0);
      b_cero <= (bus.B == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Y        <= '0;
      bus.valido   <= 1'b0;
      bus.desborde <= 1'b0;
      bus.div_cero <= 1'b0;
    end else begin
      bus.valido <= (estado == FIN);
      if (estado == FIN) begin
        bus.Y        <= y_sig;
        bus.desborde <= desb_sig;
        bus.div_cero <= dz_sig;
      end
    end
  end

  assign bus.ocupado = (estado != IDLE);

endmodule

// File: tb/tb_divisor_punto_fijo.sv
// Scoreboard bench for divisor_punto_fijo: expected results are pushed when a
// start is driven and popped when valido is seen.
module tb_divisor_punto_fijo;
  import divisor_punto_fijo_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  divisor_punto_fijo_if bus();

  divisor_punto_fijo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [Width-1:0] y;
    logic             dsb;
    logic             dz;
    int               lat;
    int               t0;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  // Reference from the arithmetic definition, not the shift/subtract algorithm
  function automatic exp_t model(input logic [Width-1:0] a, input logic [Width-1:0] b);
    exp_t   e;
    longint sa, sbv, ua, ub, q, t, lim;
    logic   neg;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = (sa < 0) ? -sa : sa;
    ub  = (sbv < 0) ? -sbv : sbv;
    neg = (sa < 0) != (sbv < 0);
    lim = (longint'(1) << (Width-1)) - 1;
    e.t0  = 0;
    e.lat = (sa == 0 || sbv == 0) ? 1 : Width + Presicion + 1;
    e.y = '0; e.dsb = 1'b0; e.dz = 1'b0;
    if (sa == 0) begin
      e.y = '0;
    end else if (sbv == 0) begin
      e.y = (sa < 0) ? minimo : maximo; e.dsb = 1'b1; e.dz = 1'b1;
    end else begin
      q = (ua << Presicion) / ub;
      if (q > lim) begin
        e.y = neg ? minimo : maximo; e.dsb = 1'b1;
      end else begin
        t = neg ? -q : q;
        e.y = t[Width-1:0];
      end
    end
    return e;
  endfunction

  // Caller positions itself (negedge or valido cycle); returns 1 time unit after edge 0
  task automatic start_div(input logic [Width-1:0] a, input logic [Width-1:0] b);
    exp_t e;
    e = model(a, b);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    e.t0 = cyc;
    sb.push_back(e);
    bus.start = 1'b0;
  endtask

  task automatic wait_result(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.valido === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.A = '0; bus.B = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (bus.Y !== '0) begin fails++; $display("FAIL reset_y: got %h want 0", bus.Y); end
    tests++; if (bus.valido !== 1'b0) begin fails++; $display("FAIL reset_valido: got %b want 0", bus.valido); end
    tests++; if (bus.ocupado !== 1'b0) begin fails++; $display("FAIL reset_ocupado: got %b want 0", bus.ocupado); end
    tests++; if ({bus.desborde, bus.div_cero} !== 2'b00) begin
      fails++; $display("FAIL reset_flags: got %b%b want 00", bus.desborde, bus.div_cero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divide();
    logic [Width-1:0] va[8], vb[8];
    exp_t e; bit got;
    va[0] = 25'h0030000;  vb[0] = 25'h0020000;   // 3.0 / 2.0
    va[1] = 25'h1FF0000;  vb[1] = 25'h0030000;   // -1.0 / 3.0
    va[2] = 25'h0C80000;  vb[2] = 25'h0008000;   // 200 / 0.5 saturates
    va[3] = 25'h0C80000;  vb[3] = 25'h1FF8000;   // 200 / -0.5 saturates negative
    va[4] = 25'h1000000;  vb[4] = 25'h1000000;   // most negative / itself
    va[5] = 25'($urandom); vb[5] = 25'($urandom);
    va[6] = 25'($urandom); vb[6] = 25'($urandom_range(1, 25'h3FFFF));
    va[7] = 25'($urandom_range(1, 25'h0FFFF)); vb[7] = 25'h1000000 | 25'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_div(va[i], vb[i]);
      tests++; if (bus.ocupado !== 1'b1) begin fails++; $display("FAIL div%0d_ocupado: got %b want 1", i, bus.ocupado); end
      wait_result(got);
      e = sb.pop_front();
      tests++;
      if (!got) begin fails++; $display("FAIL div%0d_timeout: no valido, want latency %0d", i, e.lat); end
      else begin
        if (bus.Y !== e.y) begin fails++; $display("FAIL div%0d_y: A=%h B=%h got %h want %h", i, va[i], vb[i], bus.Y, e.y); end
        tests++; if (bus.desborde !== e.dsb) begin fails++; $display("FAIL div%0d_desborde: got %b want %b", i, bus.desborde, e.dsb); end
        tests++; if (bus.div_cero !== e.dz) begin fails++; $display("FAIL div%0d_div_cero: got %b want %b", i, bus.div_cero, e.dz); end
        tests++; if (cyc - e.t0 != e.lat) begin fails++; $display("FAIL div%0d_latency: got %0d want %0d", i, cyc - e.t0, e.lat); end
        tests++; if (bus.ocupado !== 1'b0) begin fails++; $display("FAIL div%0d_ocupado_end: got %b want 0", i, bus.ocupado); end
        @(negedge clk);
        tests++; if (bus.valido !== 1'b0) begin fails++; $display("FAIL div%0d_pulse: valido %b want 0", i, bus.valido); end
      end
    end
  endtask

  task automatic test_zero();
    logic [Width-1:0] va[4], vb[4];
    exp_t e; bit got;
    va[0] = 25'h1FF0000; vb[0] = 25'h0;
    va[1] = 25'h0;       vb[1] = 25'h0;
    va[2] = 25'h0;       vb[2] = 25'h0050000;
    va[3] = 25'h0050000; vb[3] = 25'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_div(va[i], vb[i]);
      wait_result(got);
      e = sb.pop_front();
      tests++;
      if (!got) begin fails++; $display("FAIL zero%0d_timeout: no valido", i); end
      else begin
        if (bus.Y !== e.y) begin fails++; $display("FAIL zero%0d_y: got %h want %h", i, bus.Y, e.y); end
        tests++; if ({bus.desborde, bus.div_cero} !== {e.dsb, e.dz}) begin
          fails++; $display("FAIL zero%0d_flags: got %b%b want %b%b", i, bus.desborde, bus.div_cero, e.dsb, e.dz); end
        tests++; if (cyc - e.t0 != 1) begin fails++; $display("FAIL zero%0d_latency: got %0d want 1", i, cyc - e.t0); end
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e; bit got; int extra;
    @(negedge clk);
    start_div(25'h0030000, 25'h0020000);
    repeat (10) @(negedge clk);
    bus.A = 25'h0050000; bus.B = 25'h0070000; bus.start = 1'b1;   // lands on edge 10
    @(posedge clk); #1 bus.start = 1'b0;
    wait_result(got);
    e = sb.pop_front();
    tests++;
    if (!got) begin fails++; $display("FAIL ignore_timeout: no valido"); end
    else begin
      if (bus.Y !== e.y) begin fails++; $display("FAIL ignore_y: got %h want %h", bus.Y, e.y); end
      tests++; if (cyc - e.t0 != e.lat) begin fails++; $display("FAIL ignore_latency: got %0d want %0d", cyc - e.t0, e.lat); end
    end
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.valido === 1'b1) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL ignore_extra_valido: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    exp_t e; bit got;
    @(negedge clk);
    start_div(25'h0C80000, 25'h0008000);
    wait_result(got);
    e = sb.pop_front();
    tests++;
    if (!got) begin fails++; $display("FAIL b2b_first_timeout: no valido"); end
    else if (bus.Y !== e.y) begin fails++; $display("FAIL b2b_first_y: got %h want %h", bus.Y, e.y); end
    // still in the valido cycle here
    start_div(25'h1FF0000, 25'h0030000);
    wait_result(got);
    e = sb.pop_front();
    tests++;
    if (!got) begin fails++; $display("FAIL b2b_second_timeout: no valido"); end
    else begin
      if (bus.Y !== e.y) begin fails++; $display("FAIL b2b_second_y: got %h want %h", bus.Y, e.y); end
      tests++; if (cyc - e.t0 != e.lat) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", cyc - e.t0, e.lat); end
    end
  endtask

  task automatic test_reset_abort();
    exp_t e; bit got; int seen;
    @(negedge clk);
    start_div(25'h0030000, 25'h0020000);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    tests++; if (bus.Y !== '0) begin fails++; $display("FAIL abort_y: got %h want 0", bus.Y); end
    tests++; if ({bus.valido, bus.ocupado, bus.desborde, bus.div_cero} !== 4'b0) begin
      fails++; $display("FAIL abort_outputs: got %b%b%b%b want 0000", bus.valido, bus.ocupado, bus.desborde, bus.div_cero); end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.valido === 1'b1) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.valido === 1'b1) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_valido: got %0d pulses want 0", seen); end
    start_div(25'h1FF0000, 25'h0030000);
    wait_result(got);
    e = sb.pop_front();
    tests++;
    if (!got) begin fails++; $display("FAIL abort_next_timeout: no valido"); end
    else begin
      if (bus.Y !== e.y) begin fails++; $display("FAIL abort_next_y: got %h want %h", bus.Y, e.y); end
      tests++; if (cyc - e.t0 != e.lat) begin fails++; $display("FAIL abort_next_latency: got %0d want %0d", cyc - e.t0, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
